// File: rtl/proc_run_pkg.sv
// proc_run_pkg: shared types for the processor run controller.
package proc_run_pkg;

  // Width of the stored run index; NUM_RUNS must not exceed 2**RUN_IDX_W.
  localparam int unsigned RUN_IDX_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_HOLD,
    ST_RUN,
    ST_CHECK,
    ST_DONE
  } run_state_e;

  typedef struct packed {
    logic                 pass;
    logic                 timeout;
    logic [RUN_IDX_W-1:0] run_idx;
  } run_status_t;

endpackage

// File: rtl/proc_run_ctrl_sat_counter.sv
// sat_counter: W-bit up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // Clear wins over increment; increment stops at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl: reset-hold / run / check sequencer around the RISC core.
// Optional retire counter enabled by defining PROC_RUN_PERF_EN.
module proc_run_ctrl
  import proc_run_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 1000,
  parameter int unsigned NUM_RUNS   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            core_halt,
  input  logic                            core_retire,
  input  logic [DATA_W-1:0]               core_result,
  input  logic [DATA_W-1:0]               expected,
  output logic                            core_rst,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic                            timeout,
  output logic [$clog2(NUM_RUNS+1)-1:0]   run_idx,
  output logic [CNT_W-1:0]                cycle_count
`ifdef PROC_RUN_PERF_EN
  ,
  output logic [CNT_W-1:0]                retire_count
`endif
);

  localparam int unsigned RIDX_W = $clog2(NUM_RUNS + 1);
  localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  run_state_e  state_q, state_d;
  run_status_t status_q, status_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic core_rst_q, core_rst_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic at_limit;
  logic last_run;
  logic cnt_clr;
  logic cyc_inc;

  assign at_limit = (cycle_count == CNT_W'(TIMEOUT - 1));
  assign last_run = (status_q.run_idx == RUN_IDX_W'(NUM_RUNS - 1));

  // Next state, run status and reset-hold down-counter.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    hold_d   = hold_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_RST_HOLD;
          hold_d   = HOLD_W'(RST_CYCLES - 1);
          status_d = '0;
        end
      end
      ST_RST_HOLD: begin
        if (hold_q == '0) state_d = ST_RUN;
        else              hold_d  = hold_q - HOLD_W'(1);
      end
      ST_RUN: begin
        if (core_halt) begin
          state_d = ST_CHECK;
        end else if (at_limit) begin
          state_d          = ST_DONE;
          status_d.timeout = 1'b1;
          status_d.pass    = 1'b0;
        end
      end
      ST_CHECK: begin
        if (core_result != expected) begin
          state_d       = ST_DONE;
          status_d.pass = 1'b0;
        end else if (last_run) begin
          state_d       = ST_DONE;
          status_d.pass = 1'b1;
        end else begin
          state_d          = ST_RST_HOLD;
          hold_d           = HOLD_W'(RST_CYCLES - 1);
          status_d.run_idx = status_q.run_idx + RUN_IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they align with it.
    core_rst_d = !((state_d == ST_RUN) || (state_d == ST_CHECK));
    busy_d     = (state_d == ST_RST_HOLD) || (state_d == ST_RUN) || (state_d == ST_CHECK);
    done_d     = (state_d == ST_DONE);
  end

  // State, status and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      status_q   <= '0;
      hold_q     <= '0;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      hold_q     <= hold_d;
      core_rst_q <= core_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Counters restart on every entry into the reset hold. The halt and
  // watchdog cycles do not count, so the value freezes at the RUN cycles before them.
  assign cnt_clr = (state_d == ST_RST_HOLD) && (state_q != ST_RST_HOLD);
  assign cyc_inc = (state_q == ST_RUN) && !core_halt && !at_limit;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cyc_inc),
    .count (cycle_count)
  );

`ifdef PROC_RUN_PERF_EN
  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   ((state_q == ST_RUN) && core_retire),
    .count (retire_count)
  );
`else
  logic unused_core_retire;
  assign unused_core_retire = core_retire;
`endif

  assign core_rst = core_rst_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = status_q.pass;
  assign timeout  = status_q.timeout;
  assign run_idx  = status_q.run_idx[RIDX_W-1:0];

endmodule
